// File: rtl/fruit_pkg.sv
// Shared types, screen constants and the level-to-interval helper for the fruit game.
package fruit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      LAUNCH = 2'd2,
      FLIGHT = 2'd3
   } spawner_state_t;

   localparam logic [9:0] X_MAX    = 10'd639;
   localparam logic [9:0] Y_MAX    = 10'd479;
   localparam logic [9:0] X_CENTER = 10'd320;

   // 10-bit two's complement velocity
   typedef logic [9:0] vel_t;

   // Frames between launches: base minus level*step, floored, never wrapping below zero.
   function automatic logic [7:0] launch_interval(
      input logic [7:0] cut,
      input logic [7:0] base,
      input logic [7:0] step,
      input logic [7:0] floor_v
   );
      logic [3:0]  level;
      logic [11:0] dec;
      if (cut[7:2] > 6'd15) begin
         level = 4'd15;
      end else begin
         level = cut[5:2];
      end
      dec = {8'd0, level} * {4'd0, step};
      if ((dec + {4'd0, floor_v}) >= {4'd0, base}) begin
         return floor_v;
      end else begin
         return base - dec[7:0];
      end
   endfunction

endpackage

// File: rtl/fruit_spawner_lfsr16.sv
// 16-bit Galois LFSR (right shift). Reusable for any per-fruit random choice.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] TAPS = 16'hB400
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic        enable,
   output logic [15:0] state
);

   logic [15:0] state_r;

   // Shift once per enabled frame; seed must be nonzero or the sequence sticks at zero
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_r <= SEED;
      end else if (enable) begin
         state_r <= {1'b0, state_r[15:1]} ^ (state_r[0] ? TAPS : 16'h0000);
      end
   end

   assign state = state_r;

endmodule

// File: rtl/fruit_spawner.sv
// Launch controller: times each throw, picks random start X / velocities, waits for the fruit to clear.
module fruit_spawner
   import fruit_pkg::*;
#(
   parameter int unsigned BASE_INTERVAL = 120,
   parameter int unsigned STEP          = 6,
   parameter int unsigned MIN_INTERVAL  = 30,
   parameter int unsigned X_SPAWN_MIN   = 64,
   parameter int unsigned VY_BASE       = 12,
   parameter int unsigned ACK_TIMEOUT   = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       enable,
   input  logic       fruit_active,
   input  logic [7:0] cut_count,
   output logic       new_fruit,
   output logic [9:0] spawn_x,
   output logic [9:0] spawn_vx,
   output logic [9:0] spawn_vy,
   output logic [7:0] spawn_count
);

   localparam logic [7:0] BASE_W  = 8'(BASE_INTERVAL);
   localparam logic [7:0] STEP_W  = 8'(STEP);
   localparam logic [7:0] MIN_W   = 8'(MIN_INTERVAL);
   localparam logic [9:0] X_MIN_W = 10'(X_SPAWN_MIN);
   localparam logic [9:0] VY_W    = 10'(VY_BASE);
   localparam logic [7:0] ACK_W   = 8'(ACK_TIMEOUT);

   spawner_state_t state_r, state_s;
   logic [7:0]     counter_r, counter_s;
   logic           seen_r, seen_s;
   logic           launch_s;
   logic           new_fruit_r;
   logic [9:0]     spawn_x_r, spawn_x_s;
   vel_t           spawn_vx_r, spawn_vx_s;
   vel_t           spawn_vy_r, spawn_vy_s;
   vel_t           vx_mag_s;
   logic [7:0]     spawn_count_r;
   logic [7:0]     interval_s;
   logic [15:0]    lfsr_s;
   logic           unused_lfsr_bits_s;

   lfsr16 #(.SEED(LFSR_SEED), .TAPS(16'hB400)) u_lfsr (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .enable    (1'b1),
      .state     (lfsr_s)
   );

   assign unused_lfsr_bits_s = ^lfsr_s[15:13];
   assign interval_s = launch_interval(cut_count, BASE_W, STEP_W, MIN_W);

   // Launch values from the LFSR state that is current on the launching edge
   always_comb begin
      spawn_x_s = X_MIN_W + {1'b0, lfsr_s[8:0]};
      vx_mag_s  = {8'd0, lfsr_s[10:9]} + 10'd1;
      if (spawn_x_s < X_CENTER) begin
         spawn_vx_s = vx_mag_s;
      end else begin
         spawn_vx_s = 10'd0 - vx_mag_s;
      end
      spawn_vy_s = 10'd0 - (VY_W + {8'd0, lfsr_s[12:11]});
   end

   // Next-state logic: interval countdown, one-frame launch, flight watch with ack timeout
   always_comb begin
      state_s   = state_r;
      counter_s = counter_r;
      seen_s    = seen_r;
      launch_s  = 1'b0;
      if (!enable) begin
         state_s   = IDLE;
         counter_s = 8'd0;
         seen_s    = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s   = WAIT;
               counter_s = interval_s;
            end
            WAIT: begin
               if ((counter_r == 8'd1) && !fruit_active) begin
                  state_s  = LAUNCH;
                  launch_s = 1'b1;
               end else if (counter_r > 8'd1) begin
                  counter_s = counter_r - 8'd1;
               end else begin
                  counter_s = counter_r;
               end
            end
            LAUNCH: begin
               state_s   = FLIGHT;
               seen_s    = 1'b0;
               counter_s = ACK_W;
            end
            FLIGHT: begin
               if (seen_r && !fruit_active) begin
                  state_s   = WAIT;
                  counter_s = interval_s;
                  seen_s    = 1'b0;
               end else if (!seen_r && (counter_r == 8'd0)) begin
                  state_s   = WAIT;
                  counter_s = interval_s;
                  seen_s    = 1'b0;
               end else begin
                  seen_s = seen_r | fruit_active;
                  if (!seen_r) begin
                     counter_s = counter_r - 8'd1;
                  end else begin
                     counter_s = counter_r;
                  end
               end
            end
            default: begin
               state_s   = IDLE;
               counter_s = 8'd0;
               seen_s    = 1'b0;
            end
         endcase
      end
   end

   // State, strobe and held launch registers; spawn values and count only change on a launch
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_r       <= IDLE;
         counter_r     <= 8'd0;
         seen_r        <= 1'b0;
         new_fruit_r   <= 1'b0;
         spawn_x_r     <= X_CENTER;
         spawn_vx_r    <= 10'd0;
         spawn_vy_r    <= 10'd0;
         spawn_count_r <= 8'd0;
      end else begin
         state_r     <= state_s;
         counter_r   <= counter_s;
         seen_r      <= seen_s;
         new_fruit_r <= launch_s;
         if (launch_s) begin
            spawn_x_r  <= spawn_x_s;
            spawn_vx_r <= spawn_vx_s;
            spawn_vy_r <= spawn_vy_s;
            if (spawn_count_r != 8'd255) begin
               spawn_count_r <= spawn_count_r + 8'd1;
            end
         end
      end
   end

   assign new_fruit   = new_fruit_r;
   assign spawn_x     = spawn_x_r;
   assign spawn_vx    = spawn_vx_r;
   assign spawn_vy    = spawn_vy_r;
   assign spawn_count = spawn_count_r;

endmodule

// File: tb/tb_fruit_spawner.sv
// Directed bench for fruit_spawner: launch timing, flight handling, level intervals, abort and reset.
module tb_fruit_spawner;

   logic       Reset;
   logic       frame_clk;
   logic       enable;
   logic       fruit_active;
   logic [7:0] cut_count;
   logic       new_fruit;
   logic [9:0] spawn_x;
   logic [9:0] spawn_vx;
   logic [9:0] spawn_vy;
   logic [7:0] spawn_count;

   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   logic [15:0] lfsr_m;
   logic [15:0] lfsr_pre;
   logic [9:0]  last_x;
   int          n;
   int          p;

   fruit_spawner dut (
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .enable       (enable),
      .fruit_active (fruit_active),
      .cut_count    (cut_count),
      .new_fruit    (new_fruit),
      .spawn_x      (spawn_x),
      .spawn_vx     (spawn_vx),
      .spawn_vy     (spawn_vy),
      .spawn_count  (spawn_count)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame: remember the LFSR value the edge sees, advance the model, sample 1 unit later
   task automatic tick();
      lfsr_pre = lfsr_m;
      @(posedge frame_clk);
      if (!Reset) lfsr_m = lfsr_next(lfsr_m);
      #1;
   endtask

   task automatic wait_pulse(input int bound, output int cnt);
      int i;
      cnt = -1;
      i = 0;
      while ((cnt < 0) && (i < bound)) begin
         tick();
         i++;
         if (new_fruit === 1'b1) cnt = i;
      end
   endtask

   task automatic run_ticks(input int num, output int pulses);
      pulses = 0;
      for (int k = 0; k < num; k++) begin
         tick();
         if (new_fruit === 1'b1) pulses++;
      end
   endtask

   task automatic check_launch(input string tag, input logic [7:0] exp_count);
      logic [9:0] ex, em, evx, evy;
      ex  = 10'd64 + {1'b0, lfsr_pre[8:0]};
      em  = {8'd0, lfsr_pre[10:9]} + 10'd1;
      evx = (ex < 10'd320) ? em : (10'd0 - em);
      evy = 10'd0 - (10'd12 + {8'd0, lfsr_pre[12:11]});
      last_x = ex;
      chk({tag, "_count"}, {24'd0, spawn_count}, {24'd0, exp_count});
      chk({tag, "_x"},     {22'd0, spawn_x},     {22'd0, ex});
      chk({tag, "_vx"},    {22'd0, spawn_vx},    {22'd0, evx});
      chk({tag, "_vy"},    {22'd0, spawn_vy},    {22'd0, evy});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_new_fruit"}, {31'd0, new_fruit},  32'd0);
      chk({tag, "_x"},         {22'd0, spawn_x},    32'd320);
      chk({tag, "_vx"},        {22'd0, spawn_vx},   32'd0);
      chk({tag, "_vy"},        {22'd0, spawn_vy},   32'd0);
      chk({tag, "_count"},     {24'd0, spawn_count}, 32'd0);
   endtask

   initial begin
      Reset        = 1'b1;
      enable       = 1'b0;
      fruit_active = 1'b0;
      cut_count    = 8'd0;
      lfsr_m       = 16'hACE1;
      lfsr_pre     = 16'hACE1;
      last_x       = 10'd320;
      repeat (2) @(posedge frame_clk);
      #1;
      check_reset_outputs("reset");

      // Disabled: nothing launches for 200 frames
      Reset = 1'b0;
      run_ticks(200, p);
      chk("idle_no_pulse", p, 32'd0);
      chk("idle_count", {24'd0, spawn_count}, 32'd0);

      // Level 0: edge 0 enters WAIT, launch on the 120th edge after it
      enable = 1'b1;
      tick();
      chk("wait_entry_quiet", {31'd0, new_fruit}, 32'd0);
      wait_pulse(400, n);
      chk("first_interval", n, 32'd120);
      check_launch("launch1", 8'd1);
      tick();
      chk("pulse1_width", {31'd0, new_fruit}, 32'd0);

      // Fruit on screen sampled on edges 122..180 holds off the next wait
      fruit_active = 1'b1;
      run_ticks(59, p);
      chk("held_by_active", p, 32'd0);
      fruit_active = 1'b0;
      tick();
      chk("clear_edge_quiet", {31'd0, new_fruit}, 32'd0);
      wait_pulse(400, n);
      chk("after_clear_interval", n, 32'd120);
      check_launch("launch2", 8'd2);
      tick();
      chk("pulse2_width", {31'd0, new_fruit}, 32'd0);

      // No ack: LAUNCH 1 + FLIGHT 4 (counter 3,2,1,0) + 120 = 125 frames, 124 after width tick
      wait_pulse(400, n);
      chk("timeout_spacing", n, 32'd124);
      check_launch("launch3", 8'd3);

      // Level 5 -> interval 90, spacing 95
      cut_count = 8'd20;
      tick();
      chk("pulse3_width", {31'd0, new_fruit}, 32'd0);
      wait_pulse(400, n);
      chk("level5_spacing", n, 32'd94);
      check_launch("launch4", 8'd4);

      // cut_count 255 -> level clamps at 15, interval 30, spacing 35
      cut_count = 8'd255;
      tick();
      wait_pulse(400, n);
      chk("level15_spacing", n, 32'd34);
      check_launch("launch5", 8'd5);

      // Abort 60 frames into a level-0 wait (WAIT entry 5 edges after the launch)
      cut_count = 8'd0;
      tick();
      run_ticks(64, p);
      chk("abort_pre_quiet", p, 32'd0);
      enable = 1'b0;
      tick();
      chk("abort_new_fruit", {31'd0, new_fruit}, 32'd0);
      run_ticks(10, p);
      chk("abort_idle_quiet", p, 32'd0);
      chk("abort_hold_count", {24'd0, spawn_count}, 32'd5);
      chk("abort_hold_x", {22'd0, spawn_x}, {22'd0, last_x});

      // Re-enable gives a full 120-frame wait; cut_count change mid-wait is ignored
      enable = 1'b1;
      tick();
      cut_count = 8'd255;
      wait_pulse(400, n);
      chk("reenable_interval", n, 32'd120);
      check_launch("launch6", 8'd6);

      // Reset in FLIGHT: outputs clear without waiting for an edge
      tick();
      chk("flight_quiet", {31'd0, new_fruit}, 32'd0);
      #2;
      Reset  = 1'b1;
      lfsr_m = 16'hACE1;
      #1;
      check_reset_outputs("midflight_reset");
      tick();
      Reset = 1'b0;
      tick();
      wait_pulse(400, n);
      chk("post_reset_interval", n, 32'd30);
      check_launch("post_reset", 8'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
